// File: rtl/uart_sched_pkg.sv
// Shared types for the RX-buffer-to-UART-TX scheduler.
//   sched_state_t : scheduler FSM states
//   DATA_W        : byte width on the FIFO and transmitter sides
package uart_sched_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    READ,
    WAIT_DATA,
    SEND
  } sched_state_t;

endpackage

// File: rtl/sched_idle_timer.sv
// Idle timer for the scheduler: counts cycles since the last FIFO write
// while the scheduler is armed.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   clr_i  : clear the count (FIFO write, burst trigger, or not armed)
//   run_i  : advance the count; low freezes it
//   tc_o   : count has reached IDLE_TIMEOUT-1
module sched_idle_timer
  import uart_sched_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic run_i,
  output logic tc_o
);

  localparam int CW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(IDLE_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == LAST);

  // The count holds at the terminal value so it never wraps while frozen
  // at timeout with the scheduler disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i && !tc_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Drains the RX caching FIFO into the UART transmitter in bursts. A burst
// starts on a fill threshold, an idle timeout or a flush request; bytes are
// popped one at a time and handed to the transmitter.
//
// Handshake: a byte transfers on every rising edge where tx_valid_o and
// tx_ready_i are both high; tx_valid_o and tx_data_o stay stable from the
// cycle tx_valid_o rises until that transfer edge.
//
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   enable_i             : low blocks new bursts and ends a burst after the
//                          byte in flight
//   flush_i              : single-cycle request to drain the FIFO completely
//   fifo_wr_i            : FIFO write strobe, restarts the idle timer
//   fifo_empty_i         : FIFO empty flag
//   fifo_count_i         : FIFO occupancy
//   fifo_read_en_o       : one-cycle pop strobe
//   fifo_data_i          : FIFO read data, qualified by fifo_data_valid_i
//   tx_data_o/tx_valid_o : byte offered to the transmitter
//   tx_ready_i           : transmitter ready
//   busy_o               : burst in progress (READ, WAIT_DATA, SEND)
//   sent_count_o         : bytes accepted by the transmitter, wraps
//   err_no_data_o        : sticky, a pop returned no data in time
//   state_o              : current FSM state for observation
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int ADDR_WIDTH   = 9,
  parameter int THRESHOLD    = 16,
  parameter int MAX_BURST    = 64,
  parameter int IDLE_TIMEOUT = 50000,
  parameter int DATA_TIMEOUT = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                flush_i,
  input  logic                fifo_wr_i,
  input  logic                fifo_empty_i,
  input  logic [ADDR_WIDTH:0] fifo_count_i,
  output logic                fifo_read_en_o,
  input  logic [DATA_W-1:0]   fifo_data_i,
  input  logic                fifo_data_valid_i,
  output logic [DATA_W-1:0]   tx_data_o,
  output logic                tx_valid_o,
  input  logic                tx_ready_i,
  output logic                busy_o,
  output logic [15:0]         sent_count_o,
  output logic                err_no_data_o,
  output sched_state_t        state_o
);

  localparam int WW = $clog2(DATA_TIMEOUT + 1);

  sched_state_t      state_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_valid_q;
  logic [15:0]       sent_q;
  logic [15:0]       burst_q;
  logic [WW-1:0]     wait_q;
  logic              err_q;
  logic              flush_pend_q;

  logic idle_tc;
  logic trigger;
  logic last_byte;

  assign trigger = enable_i &&
                   (fifo_count_i >= (ADDR_WIDTH + 1)'(THRESHOLD) ||
                    idle_tc || flush_pend_q);

  // Burst ends after this handshake: FIFO drained, cap reached on a
  // non-flush burst, or the scheduler was disabled.
  assign last_byte = fifo_empty_i || !enable_i ||
                     (!flush_pend_q && (burst_q + 16'd1 == 16'(MAX_BURST)));

  sched_idle_timer #(
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (fifo_wr_i || state_q != ARM || trigger),
    .run_i (state_q == ARM && enable_i),
    .tc_o  (idle_tc)
  );

  // Pop is decoded from the registered state so it lands one cycle after
  // the trigger and is suppressed when the FIFO has run dry.
  assign fifo_read_en_o = (state_q == READ) && !fifo_empty_i;
  assign busy_o         = (state_q == READ) || (state_q == WAIT_DATA) ||
                          (state_q == SEND);
  assign tx_data_o      = tx_data_q;
  assign tx_valid_o     = tx_valid_q;
  assign sent_count_o   = sent_q;
  assign err_no_data_o  = err_q;
  assign state_o        = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      sent_q       <= '0;
      burst_q      <= '0;
      wait_q       <= '0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_i && !fifo_empty_i) state_q <= ARM;
        end
        ARM: begin
          if (fifo_empty_i) begin
            state_q <= IDLE;
          end else if (trigger) begin
            state_q <= READ;
          end
        end
        READ: begin
          if (fifo_empty_i) begin
            state_q      <= IDLE;
            burst_q      <= '0;
            flush_pend_q <= 1'b0;
          end else begin
            // The pop cycle counts as the first cycle of the data wait.
            wait_q  <= WW'(1);
            state_q <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (fifo_data_valid_i) begin
            tx_data_q  <= fifo_data_i;
            tx_valid_q <= 1'b1;
            state_q    <= SEND;
          end else if (wait_q >= WW'(DATA_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            burst_q <= '0;
            state_q <= IDLE;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        SEND: begin
          if (tx_valid_q && tx_ready_i) begin
            tx_valid_q <= 1'b0;
            sent_q     <= sent_q + 16'd1;
            if (last_byte) begin
              burst_q <= '0;
              state_q <= IDLE;
              if (fifo_empty_i) flush_pend_q <= 1'b0;
            end else begin
              burst_q <= burst_q + 16'd1;
              state_q <= READ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      // A new flush request outranks the end-of-burst clear.
      if (flush_i) flush_pend_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;
  import uart_sched_pkg::*;

  localparam int AW = 9;
  localparam int T  = 1000;  // shortened idle timeout keeps the run brief

  // clock / reset and DUT signals
  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          enable_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          fifo_wr_i = 1'b0;
  logic          fifo_empty_i = 1'b1;
  logic [AW:0]   fifo_count_i = '0;
  logic          fifo_read_en_o;
  logic [7:0]    fifo_data_i = '0;
  logic          fifo_data_valid_i = 1'b0;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i = 1'b0;
  logic          busy_o;
  logic [15:0]   sent_count_o;
  logic          err_no_data_o;
  sched_state_t  state_o;

  always #5 clk_i = ~clk_i;

  uart_tx_scheduler #(
    .ADDR_WIDTH(AW), .THRESHOLD(16), .MAX_BURST(64),
    .IDLE_TIMEOUT(T), .DATA_TIMEOUT(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .flush_i(flush_i),
    .fifo_wr_i(fifo_wr_i), .fifo_empty_i(fifo_empty_i),
    .fifo_count_i(fifo_count_i), .fifo_read_en_o(fifo_read_en_o),
    .fifo_data_i(fifo_data_i), .fifo_data_valid_i(fifo_data_valid_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .busy_o(busy_o), .sent_count_o(sent_count_o),
    .err_no_data_o(err_no_data_o), .state_o(state_o)
  );

  // bench state
  logic [7:0] wr_byte = '0;
  logic       suppress = 1'b0;
  logic       fifo_clr = 1'b0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] pop_b;
  int         rd_cnt = 0;
  int         rd_double = 0;
  logic       rd_prev = 1'b0;
  int         total = 0;
  int         bad = 0;
  int         exp_sent = 0;

  // FIFO model: pops on the read strobe, returns data the next cycle
  always @(posedge clk_i) begin
    fifo_data_valid_i <= 1'b0;
    if (fifo_clr) begin
      fifo_q.delete();
    end else begin
      if (fifo_read_en_o && !suppress && fifo_q.size() > 0) begin
        pop_b = fifo_q.pop_front();
        fifo_data_i       <= pop_b;
        fifo_data_valid_i <= 1'b1;
      end
      if (fifo_wr_i) fifo_q.push_back(wr_byte);
    end
    fifo_count_i <= (AW + 1)'(fifo_q.size());
    fifo_empty_i <= (fifo_q.size() == 0);
  end

  // monitor: collects accepted bytes and read strobes mid-cycle
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (tx_valid_o && tx_ready_i) got_q.push_back(tx_data_o);
      if (fifo_read_en_o) begin
        rd_cnt++;
        if (rd_prev) rd_double++;
      end
      rd_prev = fifo_read_en_o;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_byte   = b;
    fifo_wr_i = 1'b1;
    if (!suppress) begin
      exp_q.push_back(b);
      exp_sent++;
    end
    step();
    fifo_wr_i = 1'b0;
  endtask

  task automatic check_sb(input string tag);
    chk({tag, "_n"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_sent(input string tag, input int budget);
    int k = 0;
    while (sent_count_o !== 16'(exp_sent) && k < budget) begin
      step();
      k++;
    end
    chk(tag, sent_count_o, 16'(exp_sent));
  endtask

  task automatic wait_read(input string tag, output int k);
    k = 0;
    while (fifo_read_en_o !== 1'b1 && k < 3 * T) begin
      step();
      k++;
    end
    chk({tag, "_seen"}, fifo_read_en_o, 1);
  endtask

  task automatic wait_txv(input string tag);
    int k = 0;
    while (tx_valid_o !== 1'b1 && k < 500) begin
      step();
      k++;
    end
    chk({tag, "_txv"}, tx_valid_o, 1);
  endtask

  task automatic wait_state(input sched_state_t st, input string tag);
    int k = 0;
    while (state_o !== st && k < 3 * T) begin
      step();
      k++;
    end
    chk(tag, 32'(state_o), 32'(st));
  endtask

  task automatic wait_burst_end(input string tag);
    int k = 0;
    while (busy_o !== 1'b1 && k < 500) begin
      step();
      k++;
    end
    chk({tag, "_start"}, busy_o, 1);
    wait_state(IDLE, {tag, "_end"});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_txv"}, tx_valid_o, 0);
    chk({tag, "_rd"}, fifo_read_en_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_sent"}, sent_count_o, 0);
    chk({tag, "_err"}, err_no_data_o, 0);
    chk({tag, "_txd"}, tx_data_o, 0);
    chk({tag, "_state"}, 32'(state_o), 32'(IDLE));
  endtask

  initial begin
    int r0;
    int k;
    int s0;
    int stable_bad;
    logic [7:0] d0;

    // reset state
    repeat (3) step();
    chk_all_zero("rst");
    rst_ni     = 1'b1;
    enable_i   = 1'b1;
    tx_ready_i = 1'b1;
    step();

    // threshold: 16 bytes 0x00..0x0F
    r0 = rd_cnt;
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    wait_sent("t1_sent", 400);
    chk("t1_reads", rd_cnt - r0, 16);
    chk("t1_single", rd_double, 0);
    chk("t1_state", 32'(state_o), 32'(IDLE));
    check_sb("t1_data");

    // idle timeout: 3 bytes, first pop T cycles after the last write
    write_byte(8'hA1);
    write_byte(8'hA2);
    write_byte(8'hA3);
    wait_read("t2a", k);
    chk("t2a_lat", k, T);
    wait_sent("t2a_sent", 200);
    check_sb("t2a_data");

    // idle timeout restart by a late write
    write_byte(8'hB1);
    r0 = rd_cnt;
    repeat (T - 10) step();
    chk("t2b_quiet", rd_cnt - r0, 0);
    write_byte(8'hB2);
    wait_read("t2b", k);
    chk("t2b_lat", k, T);
    wait_sent("t2b_sent", 200);
    check_sb("t2b_data");

    // burst cap: 100 queued, first burst stops at 64
    enable_i = 1'b0;
    step();
    for (int i = 0; i < 100; i++) write_byte(8'(i * 3 + 1));
    r0 = rd_cnt;
    enable_i = 1'b1;
    wait_burst_end("t3");
    chk("t3_cap", rd_cnt - r0, 64);
    wait_sent("t3_sent", 3000);
    check_sb("t3_data");

    // flush: 100 queued, drained in one burst
    enable_i = 1'b0;
    step();
    for (int i = 0; i < 100; i++) write_byte(8'(255 - i));
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    r0 = rd_cnt;
    enable_i = 1'b1;
    wait_burst_end("t4");
    chk("t4_reads", rd_cnt - r0, 100);
    chk("t4_sent", sent_count_o, 16'(exp_sent));
    check_sb("t4_data");

    // backpressure: tx_ready low for 500 cycles
    tx_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) write_byte(8'(8'hC0 + i));
    wait_txv("t5");
    d0 = tx_data_o;
    r0 = rd_cnt;
    stable_bad = 0;
    repeat (500) begin
      step();
      if (!(tx_valid_o === 1'b1 && tx_data_o === d0)) stable_bad++;
    end
    chk("t5_first", d0, 8'hC0);
    chk("t5_stable", stable_bad, 0);
    chk("t5_noread", rd_cnt - r0, 0);
    s0 = int'(sent_count_o);
    chk("t5_held", s0, exp_sent - 16);
    tx_ready_i = 1'b1;
    step();
    chk("t5_inc", sent_count_o, 16'(s0 + 1));
    wait_sent("t5_sent", 400);
    check_sb("t5_data");

    // enable dropped during SEND: byte completes, then IDLE
    tx_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) write_byte(8'(8'h50 + i));
    wait_txv("t6");
    enable_i = 1'b0;
    repeat (5) step();
    s0 = int'(sent_count_o);
    tx_ready_i = 1'b1;
    step();
    chk("t6_inc", sent_count_o, 16'(s0 + 1));
    chk("t6_state", 32'(state_o), 32'(IDLE));
    chk("t6_busy", busy_o, 0);
    chk("t6_txv", tx_valid_o, 0);
    r0 = rd_cnt;
    repeat (20) step();
    chk("t6_noread", rd_cnt - r0, 0);
    chk("t6_hold", 32'(state_o), 32'(IDLE));
    enable_i = 1'b1;
    wait_sent("t6_sent", 3 * T);
    check_sb("t6_data");

    // read timeout: data valid suppressed after a pop
    suppress = 1'b1;
    for (int i = 0; i < 16; i++) write_byte(8'(8'h70 + i));
    wait_read("t7", k);
    repeat (3) step();
    chk("t7_err_early", err_no_data_o, 0);
    step();
    chk("t7_err", err_no_data_o, 1);
    chk("t7_state", 32'(state_o), 32'(IDLE));
    repeat (20) step();
    chk("t7_sticky", err_no_data_o, 1);

    // asynchronous reset in WAIT_DATA
    wait_state(WAIT_DATA, "t8_wait");
    chk("t8_pre_sent", sent_count_o, 16'(exp_sent));
    #2 rst_ni = 1'b0;
    #1;
    chk_all_zero("t8_rst");
    fifo_clr = 1'b1;
    step();
    fifo_clr = 1'b0;
    suppress = 1'b0;
    got_q.delete();
    exp_q.delete();
    step();
    chk("t8_err_held", err_no_data_o, 0);
    rst_ni = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Sequences the receive-buffer-to-transmitter path. Decides when to drain the 512-deep RX caching FIFO: fill threshold, idle timeout or an explicit flush. Pops one byte at a time with a single-cycle read strobe, then presents it to the UART transmitter over a valid/ready handshake. Sits between the buffer and the UART TX, replacing the direct tie of the TX-ready signal to the FIFO read enable.

Parameters:
ADDR_WIDTH, 9, FIFO address width; fifo_count is ADDR_WIDTH+1 bits
THRESHOLD, 16, fifo_count level that starts a burst
MAX_BURST, 64, maximum bytes per non-flush burst
IDLE_TIMEOUT, 50000, cycles without a FIFO write before a partial burst starts (1 ms at 50 MHz)
DATA_TIMEOUT, 4, cycles allowed between fifo_read_en and fifo_data_valid

Ports:
clk  in  1  system clock (CLOCK_50 domain)
rst_n  in  1  asynchronous active-low reset
enable  in  1  scheduler enable; low blocks new bursts
flush  in  1  single-cycle request to drain the FIFO completely
fifo_wr  in  1  FIFO write strobe (rx_valid); restarts the idle timer
fifo_empty  in  1  FIFO empty flag
fifo_count  in  ADDR_WIDTH+1  FIFO occupancy
fifo_read_en  out  1  pop strobe, one cycle per byte
fifo_data  in  8  FIFO read data
fifo_data_valid  in  1  fifo_data valid, one cycle
tx_data  out  8  byte to transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter accepts when high with tx_valid
busy  out  1  burst in progress
sent_count  out  16  bytes accepted by TX, wraps at 16 bits
err_no_data  out  1  sticky: read returned no data within DATA_TIMEOUT

Behaviour:
- Reset (async, rst_n low): all outputs 0, state IDLE, idle_cnt/burst_cnt/data_wait 0, flush_pend 0. Any in-flight byte is dropped; tx_valid drops immediately.
- flush pulse sets flush_pend. flush_pend clears at the end of a burst when fifo_empty is high.
- IDLE: if enable && !fifo_empty, go to ARM.
- ARM:
  - idle_cnt increments each cycle; cleared on fifo_wr.
  - Trigger when enable && (fifo_count >= THRESHOLD || idle_cnt == IDLE_TIMEOUT-1 || flush_pend). On trigger go to READ and clear idle_cnt.
  - fifo_wr in the same cycle as a trigger: the trigger wins.
  - enable low: hold ARM, idle_cnt frozen.
  - fifo_empty while in ARM: go to IDLE.
- READ:
  - If fifo_empty: go to IDLE without asserting fifo_read_en.
  - Else assert fifo_read_en for exactly one cycle and go to WAIT_DATA. At most one read outstanding.
- WAIT_DATA:
  - On fifo_data_valid: register fifo_data into tx_data, set tx_valid the next cycle, go to SEND.
  - No valid within DATA_TIMEOUT cycles: set err_no_data and go to IDLE.
- SEND:
  - tx_valid and tx_data held stable until the cycle tx_valid && tx_ready.
  - In the handshake cycle: tx_valid cleared next edge, sent_count+1, burst_cnt+1.
  - Then go to IDLE (burst_cnt cleared) if fifo_empty, or (!flush_pend && burst_cnt+1 == MAX_BURST), or !enable. Otherwise go to READ.
- enable dropped mid-burst: the current byte completes its handshake, then IDLE. No partial byte is discarded.
- Latency: trigger to fifo_read_en = 1 cycle; fifo_data_valid to tx_valid = 1 cycle; back-to-back bytes need at least 3 cycles from handshake to the next tx_valid.
- busy = state in {READ, WAIT_DATA, SEND}.
- sent_count wraps 0xFFFF to 0x0000. err_no_data clears only on reset.

Decomposition:
- Package uart_sched_pkg: state enum sched_state_t {IDLE, ARM, READ, WAIT_DATA, SEND} and the constant DATA_W = 8.
- One sub-module, sched_idle_timer: idle_cnt counter with clear-on-fifo_wr, freeze-on-!enable and a terminal-count output. The FSM, burst counter and handshake stay in the top.

Test Plan:
- Threshold: write 16 bytes 0x00..0x0F, tx_ready tied high, enable=1. Required: exactly 16 single-cycle fifo_read_en pulses, tx_data sequence 0x00..0x0F, sent_count=16, then IDLE.
- Idle timeout: write 3 bytes, then no writes. Required: first fifo_read_en at 50000 cycles (±1) after the last fifo_wr, sent_count=3. A fifo_wr at cycle 49990 restarts the count.
- Burst cap and flush: with 100 bytes queued, a threshold trigger sends 64 bytes then returns to IDLE/ARM. A separate flush pulse with 100 bytes queued drains all 100 in one burst.
- Backpressure: tx_ready held low for 500 cycles during SEND. Required: tx_valid=1 and tx_data stable throughout, no extra fifo_read_en, count increments once on release.
- Read timeout: fifo_data_valid suppressed after a pop. Required: err_no_data=1 four cycles after fifo_read_en, FSM in IDLE, flag persists until rst_n low.
- Mid-operation: deassert enable during SEND, which completes the byte and then goes IDLE. Assert rst_n low asynchronously during WAIT_DATA: all outputs 0 immediately, sent_count=0.
